// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader: FSM encodings,
// protocol byte codes and the checksum helper.
package prog_loader_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned LEN_W   = 16;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  // Loader session states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } ldr_state_t;

  // Byte receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Running checksum: 8-bit sum modulo 256
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return 8'(acc + b);
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// uart_rx_byte: 8N1 serial byte receiver, LSB first.
// Ports: clk, reset (sync, active high), rxd (async serial in),
//        valid (1-cycle byte strobe), data (received byte),
//        frame_err (1-cycle strobe when the stop bit reads 0).
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int unsigned CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  logic            sync1, sync2, prev;
  rx_state_t       state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shreg, shreg_d;
  logic            valid_d, frame_err_d;
  logic [7:0]      data_d;

  // Synchronizer, edge-detect history and receiver state
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      prev      <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      valid     <= 1'b0;
      data      <= '0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= rxd;
      sync2     <= sync1;
      prev      <= sync2;
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      valid     <= valid_d;
      data      <= data_d;
      frame_err <= frame_err_d;
    end
  end

  // Bit timing: the start bit is re-checked half a bit after its falling
  // edge, and every later sample lands one full bit period after that.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    data_d      = data;
    case (state)
      RX_IDLE: begin
        if (prev && !sync2) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Detection already used one cycle of the half bit
        if (cnt == CW'(HALF - 2)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sync2 ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shreg_d = {sync2, shreg[7:1]};
          if (bit_idx == 3'd7) state_d = RX_STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2) begin
            valid_d = 1'b1;
            data_d  = shreg;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over a serial line and
// writes it into code memory while holding the MCU core in reset.
// Frame: 0xA5, LEN_H, LEN_L, LEN data bytes, CSUM (sum of data mod 256).
// Ports: CLK, reset (sync, active high), prog (session request level),
//        rxd (serial in), mem_we/mem_addr/mem_wdata (code-memory write),
//        cpu_hold (core reset), done/err (session result until prog falls).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned MEM_AW       = 12
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              prog,
  input  logic              rxd,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(1) << MEM_AW;

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (CLK),
    .reset     (reset),
    .rxd       (rxd),
    .valid     (rx_valid),
    .data      (rx_data),
    .frame_err (rx_ferr)
  );

  ldr_state_t        state, state_d;
  logic              mem_we_d;
  logic [MEM_AW-1:0] addr_d;
  logic [7:0]        wdata_d;
  logic [7:0]        len_hi, len_hi_d;
  logic [LEN_W-1:0]  rem, rem_d;
  logic [7:0]        sum, sum_d;
  logic [LEN_W-1:0]  len_full;

  assign len_full = {len_hi, rx_data};

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      len_hi    <= '0;
      rem       <= '0;
      sum       <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      mem_we    <= mem_we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      len_hi    <= len_hi_d;
      rem       <= rem_d;
      sum       <= sum_d;
      cpu_hold  <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
      err       <= (state_d == ST_ERR);
    end
  end

  // Session sequencing; prog low or a framing error wins over byte decode
  always_comb begin
    state_d  = state;
    mem_we_d = 1'b0;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    len_hi_d = len_hi;
    rem_d    = rem;
    sum_d    = sum;

    // Address advances once the current write has been presented
    if (mem_we) addr_d = mem_addr + MEM_AW'(1);

    case (state)
      ST_IDLE: begin
        if (prog) begin
          state_d = ST_SYNC;
          addr_d  = '0;
          sum_d   = '0;
        end
      end
      ST_SYNC, ST_LEN_H, ST_LEN_L, ST_DATA, ST_CSUM: begin
        if (!prog || rx_ferr) begin
          state_d = ST_ERR;
        end else if (rx_valid) begin
          case (state)
            ST_SYNC: begin
              if (rx_data == SYNC_BYTE) state_d = ST_LEN_H;
            end
            ST_LEN_H: begin
              len_hi_d = rx_data;
              state_d  = ST_LEN_L;
            end
            ST_LEN_L: begin
              rem_d = len_full;
              if ({1'b0, len_full} > MAX_LEN) state_d = ST_ERR;
              else if (len_full == '0)        state_d = ST_CSUM;
              else                            state_d = ST_DATA;
            end
            ST_DATA: begin
              mem_we_d = 1'b1;
              wdata_d  = rx_data;
              sum_d    = csum_add(sum, rx_data);
              rem_d    = rem - LEN_W'(1);
              if (rem == LEN_W'(1)) state_d = ST_CSUM;
            end
            default: begin
              state_d = (rx_data == sum) ? ST_DONE : ST_ERR;
            end
          endcase
        end
      end
      ST_DONE, ST_ERR: begin
        if (!prog) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader with CLKS_PER_BIT=4, MEM_AW=12.
module tb_prog_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 12;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          CLK = 1'b0;
  logic          reset, prog, rxd;
  logic          mem_we, cpu_hold, done, err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  int rxv_cnt  = 0;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];

  prog_loader #(.CLKS_PER_BIT(CPB), .MEM_AW(AW)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .prog      (prog),
    .rxd       (rxd),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected write
  always @(negedge CLK) begin
    if (dut.u_rx.valid) rxv_cnt++;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1 rxd = bits[i];
      repeat (CPB - 1) @(posedge CLK);
    end
    #1 rxd = 1'b1;
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) begin
      send_byte(tx_q.pop_front(), 1'b1);
      repeat (2) @(posedge CLK);
    end
  endtask

  // Bounded wait for the session to finish, then check flags
  task automatic wait_result(input string name, input logic exp_done, input logic exp_err);
    int k;
    k = 0;
    @(negedge CLK);
    while (!(done || err) && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_err"},  32'(err),  32'(exp_err));
    check({name, "_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  task automatic end_session(input string name);
    @(negedge CLK); prog = 1'b0;
    @(negedge CLK);
    check({name, "_clr_hold"}, 32'(cpu_hold), 32'd0);
    check({name, "_clr_flags"}, 32'({done, err}), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge CLK);
  endtask

  task automatic start_session();
    @(negedge CLK); prog = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int rv0;
    reset = 1'b1; prog = 1'b0; rxd = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_hold",  32'(cpu_hold),  32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    reset = 1'b0;
    repeat (3) @(negedge CLK);

    // Good 3-byte image
    start_session();
    check("t1_hold_sync", 32'(cpu_hold), 32'd1);
    exp_q.push_back('{12'h000, 8'h02});
    exp_q.push_back('{12'h001, 8'h00});
    exp_q.push_back('{12'h002, 8'h24});
    tx_q = '{8'hA5, 8'h00, 8'h03, 8'h02, 8'h00, 8'h24, 8'h26};
    send_q();
    wait_result("t1", 1'b1, 1'b0);
    repeat (5) @(negedge CLK);
    check("t1_hold_kept", 32'(cpu_hold), 32'd1);
    end_session("t1");

    // Checksum mismatch after two writes
    start_session();
    exp_q.push_back('{12'h000, 8'h11});
    exp_q.push_back('{12'h001, 8'h22});
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h00};
    send_q();
    wait_result("t2", 1'b0, 1'b1);
    end_session("t2");

    // Junk before sync, empty image
    start_session();
    tx_q = '{8'h55, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    wait_result("t3", 1'b1, 1'b0);
    end_session("t3");

    // Framing error on LEN_H
    start_session();
    send_byte(8'hA5, 1'b1);
    repeat (2) @(posedge CLK);
    send_byte(8'h00, 1'b0);
    wait_result("t4", 1'b0, 1'b1);
    end_session("t4");

    // Abort after first write, then a fresh 1-byte image
    start_session();
    exp_q.push_back('{12'h000, 8'hAA});
    tx_q = '{8'hA5, 8'h00, 8'h03, 8'hAA};
    send_q();
    k = 0;
    while (!mem_we && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check("t5_write_seen", 32'(k < 100), 32'd1);
    prog = 1'b0;
    @(negedge CLK);
    check("t5_err_on",  32'(err), 32'd1);
    check("t5_hold_on", 32'(cpu_hold), 32'd1);
    @(negedge CLK);
    check("t5_err_off",  32'(err), 32'd0);
    check("t5_hold_off", 32'(cpu_hold), 32'd0);
    exp_q.push_back('{12'h000, 8'h5C});
    start_session();
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h5C, 8'h5C};
    send_q();
    wait_result("t5b", 1'b1, 1'b0);
    end_session("t5b");

    // Reset mid-DATA, then a 1-cycle rxd glitch
    start_session();
    exp_q.push_back('{12'h000, 8'h01});
    exp_q.push_back('{12'h001, 8'h02});
    tx_q = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02};
    send_q();
    repeat (8) @(negedge CLK);
    reset = 1'b1; prog = 1'b0;
    @(negedge CLK);
    check("t6_we",    32'(mem_we),    32'd0);
    check("t6_addr",  32'(mem_addr),  32'd0);
    check("t6_wdata", 32'(mem_wdata), 32'd0);
    check("t6_hold",  32'(cpu_hold),  32'd0);
    check("t6_flags", 32'({done, err}), 32'd0);
    reset = 1'b0;
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge CLK);
    rv0 = rxv_cnt;
    @(posedge CLK); #1 rxd = 1'b0;
    @(posedge CLK); #1 rxd = 1'b1;
    repeat (60) @(negedge CLK);
    check("t6_glitch_no_byte", 32'(rxv_cnt - rv0), 32'd0);

    // Receiver and loader still usable after the glitch
    start_session();
    exp_q.push_back('{12'h000, 8'h77});
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h77, 8'h77};
    send_q();
    wait_result("t7", 1'b1, 1'b0);
    end_session("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL provide parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit (even, >= 4).
REQ-002 The block SHALL provide parameter MEM_AW, default 12, giving the code-memory address width.
REQ-003 CLK  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 prog  input  1  level; high requests a download session.
REQ-006 rxd  input  1  asynchronous serial in, idle high, 8N1, LSB first.
REQ-007 mem_we  output  1  one-cycle code-memory write strobe.
REQ-008 mem_addr  output  MEM_AW  code-memory write address.
REQ-009 mem_wdata  output  8  code-memory write data.
REQ-010 cpu_hold  output  1  high holds the MCU core in reset.
REQ-011 done  output  1  high after a successful download, until prog falls.
REQ-012 err  output  1  high after a failed download, until prog falls.

Function
REQ-013 rxd SHALL pass through a two-flop synchronizer before any use.
REQ-014 The byte receiver SHALL detect a start bit on a synchronized high-to-low transition.
REQ-015 The receiver SHALL re-sample at CLKS_PER_BIT/2 and discard the start as false if rxd is high.
REQ-016 The receiver SHALL sample 8 data bits, then the stop bit, each CLKS_PER_BIT cycles apart.
REQ-017 A stop bit of 0 SHALL raise a framing error.
REQ-018 The receiver SHALL issue a one-cycle byte-valid pulse in the cycle after the stop-bit sample.
REQ-019 Frame format SHALL be: 0xA5 sync, LEN_H, LEN_L, LEN data bytes, then CSUM.
REQ-020 CSUM SHALL equal the 8-bit sum, mod 256, of the data bytes.
REQ-021 FSM states SHALL be IDLE, SYNC, LEN_H, LEN_L, DATA, CSUM, DONE, ERR.
REQ-022 IDLE SHALL go to SYNC on prog=1; cpu_hold SHALL be 1 in every state except IDLE.
REQ-023 In SYNC, non-0xA5 bytes SHALL be ignored; 0xA5 SHALL advance to LEN_H.
REQ-024 LEN_H SHALL go to LEN_L after one byte; LEN_L SHALL go to DATA if LEN>0, or to CSUM if LEN=0.
REQ-025 LEN > 2^MEM_AW SHALL go to ERR on LEN_L completion.
REQ-026 Each DATA byte SHALL assert mem_we for exactly one cycle, one cycle after byte-valid.
REQ-027 Each write SHALL carry mem_wdata=byte; mem_addr SHALL start at 0 and increment after each write.
REQ-028 The FSM SHALL leave DATA for CSUM after the LEN-th write.
REQ-029 CSUM match SHALL go to DONE (done=1); mismatch SHALL go to ERR (err=1).
REQ-030 A framing error in any state from SYNC through CSUM SHALL go to ERR.
REQ-031 DONE/ERR SHALL hold until prog=0, then go to IDLE; done, err and cpu_hold SHALL clear in that cycle.
REQ-032 prog=0 in SYNC..CSUM SHALL abort to ERR within one cycle.
REQ-033 After an abort, ERR SHALL go to IDLE on the next cycle because prog is already low.
REQ-034 Writes already issued SHALL NOT be undone on abort.
REQ-035 mem_addr SHALL reset to 0 on entry to SYNC.

Reset
REQ-036 reset=1 SHALL force IDLE with mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0.
REQ-037 reset=1 SHALL clear receiver and checksum state and set both synchronizer flops to 1.
REQ-038 reset SHALL override every other input, including mid-frame.

Structure
REQ-039 The FSM state encoding, the SYNC_BYTE=0xA5 constant and the protocol byte codes SHALL live in the shared package prog_loader_pkg.
REQ-040 The serial byte receiver SHALL be a sub-module, uart_rx_byte, holding the synchronizer, bit timer and framing check.

Verification (CLKS_PER_BIT=4, MEM_AW=12)
REQ-041 Send A5 00 03 02 00 24 26 with prog=1 -> writes (0,02), (1,00), (2,24); done=1; cpu_hold stays 1 until prog=0.
REQ-042 Send A5 00 02 11 22 00 -> two writes, then err=1, done=0.
REQ-043 Send 55 A5 00 00 00 -> no writes; done=1.
REQ-044 Force the stop bit of the LEN_H byte low -> err=1; mem_we is never asserted.
REQ-045 Drop prog after the first data write -> err=1 for exactly 1 cycle, then IDLE with cpu_hold=0; raise prog and send a valid 1-byte frame -> the write lands at address 0.
REQ-046 Assert reset mid-DATA -> all outputs are 0 on the next cycle; a 1-cycle low glitch on rxd does not produce byte-valid.
